// File: rtl/ref_row_feeder_if.sv
// Row stream from the reference-window feeder into the interpolator.
// row_out/row_idx stay stable while row_valid is high and row_ready is low.
interface ref_row_feeder_if #(
  parameter int PIX_W   = 8,
  parameter int ROW_PIX = 15
);
  logic [ROW_PIX*PIX_W-1:0] row_out;
  logic                     row_valid;
  logic                     row_ready;
  logic [3:0]               row_idx;

  modport master (output row_out, row_valid, row_idx, input row_ready);
  modport slave  (input row_out, row_valid, row_idx, output row_ready);
endinterface

// File: rtl/ref_row_feeder.sv
// Fetches a clamped 15x15 reference window from byte memory and streams it as rows; row 0 valid 17 cycles after start.
// One assembly row plus one output row: reads pause in WAIT while both are occupied and row_ready is low.
module ref_row_feeder #(
  parameter int PIX_W    = 8,
  parameter int ROW_PIX  = 15,
  parameter int NUM_ROWS = 15,
  parameter int AW       = 20,
  parameter int CW       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic signed [CW-1:0] blk_x,
  input  logic signed [CW-1:0] blk_y,
  input  logic [CW-1:0]        pic_w,
  input  logic [CW-1:0]        pic_h,
  output logic                 mem_rd_en,
  output logic [AW-1:0]        mem_addr,
  input  logic [PIX_W-1:0]     mem_rd_data,
  ref_row_feeder_if.master     row_if,
  output logic                 busy,
  output logic                 done
);
  localparam int RW = ROW_PIX * PIX_W;
  localparam int JW = $clog2(ROW_PIX);

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, DRAIN} state_t;
  state_t state, state_nx;

  logic [JW-1:0]        rd_j, rd_j_nx, iss_j, beat_j;
  logic [3:0]           rd_r, rd_r_nx, xfer_cnt;
  logic signed [CW-1:0] bx_q, by_q;
  logic [CW-1:0]        w_q, h_q;
  logic                 beat_vld, asm_full, issue;
  logic                 out_free, last_beat, xfer, final_hs;
  logic [RW-1:0]        asm_row, asm_cur;

  logic signed [CW:0]   x_s, y_s, w_s, h_s;
  logic [CW-1:0]        xc, yc;
  logic [2*CW-1:0]      prod, sum;
  logic [AW-1:0]        addr_nx;

  // Edge clamping in CW+1 signed arithmetic; the sign bit flags left/top overrun.
  always_comb begin
    x_s = $signed({bx_q[CW-1], bx_q}) + $signed({{(CW+1-JW){1'b0}}, rd_j});
    y_s = $signed({by_q[CW-1], by_q}) + $signed({{(CW-3){1'b0}}, rd_r});
    w_s = $signed({1'b0, w_q});
    h_s = $signed({1'b0, h_q});
    if (x_s[CW])         xc = '0;
    else if (x_s >= w_s) xc = w_q - CW'(1);
    else                 xc = x_s[CW-1:0];
    if (y_s[CW])         yc = '0;
    else if (y_s >= h_s) yc = h_q - CW'(1);
    else                 yc = y_s[CW-1:0];
    prod    = {{CW{1'b0}}, yc} * {{CW{1'b0}}, w_q};
    sum     = prod + {{CW{1'b0}}, xc};
    addr_nx = sum[AW-1:0];
  end

  always_comb begin
    asm_cur = asm_row;
    asm_cur[beat_j*PIX_W +: PIX_W] = mem_rd_data;
  end

  assign out_free  = !row_if.row_valid || row_if.row_ready;
  assign last_beat = beat_vld && (beat_j == JW'(ROW_PIX-1));
  assign xfer      = out_free && (asm_full || last_beat);
  assign final_hs  = row_if.row_valid && row_if.row_ready && (row_if.row_idx == 4'(NUM_ROWS-1));
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next row's reads only start when the output register is empty or draining, so the
  // current row is guaranteed to leave the assembly register before new beats land.
  always_comb begin
    state_nx = state;
    rd_j_nx  = rd_j;
    rd_r_nx  = rd_r;
    issue    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = FETCH;
          rd_j_nx  = '0;
          rd_r_nx  = '0;
        end
      end
      FETCH: begin
        issue = 1'b1;
        if (rd_j == JW'(ROW_PIX-1)) begin
          rd_j_nx = '0;
          if (rd_r == 4'(NUM_ROWS-1)) begin
            state_nx = DRAIN;
          end else begin
            rd_r_nx = rd_r + 4'd1;
            if (!out_free) state_nx = WAIT;
          end
        end else begin
          rd_j_nx = rd_j + JW'(1);
        end
      end
      WAIT:    if (xfer) state_nx = FETCH;
      DRAIN:   if (final_hs) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_j             <= '0;
      rd_r             <= '0;
      iss_j            <= '0;
      beat_j           <= '0;
      beat_vld         <= 1'b0;
      mem_rd_en        <= 1'b0;
      mem_addr         <= '0;
      bx_q             <= '0;
      by_q             <= '0;
      w_q              <= '0;
      h_q              <= '0;
      xfer_cnt         <= '0;
      asm_row          <= '0;
      asm_full         <= 1'b0;
      row_if.row_out   <= '0;
      row_if.row_valid <= 1'b0;
      row_if.row_idx   <= '0;
      done             <= 1'b0;
    end else begin
      rd_j      <= rd_j_nx;
      rd_r      <= rd_r_nx;
      mem_rd_en <= issue;
      if (issue) begin
        mem_addr <= addr_nx;
        iss_j    <= rd_j;
      end
      beat_vld <= mem_rd_en;
      beat_j   <= iss_j;
      if (beat_vld) asm_row <= asm_cur;

      if (state == IDLE && start) begin
        bx_q     <= blk_x;
        by_q     <= blk_y;
        w_q      <= pic_w;
        h_q      <= pic_h;
        xfer_cnt <= '0;
      end else if (xfer) begin
        xfer_cnt <= xfer_cnt + 4'd1;
      end

      if (last_beat && !out_free) asm_full <= 1'b1;
      else if (xfer)              asm_full <= 1'b0;

      // The final beat bypasses straight into the output register when it is free.
      if (xfer) begin
        row_if.row_out   <= asm_full ? asm_row : asm_cur;
        row_if.row_valid <= 1'b1;
        row_if.row_idx   <= xfer_cnt;
      end else if (row_if.row_valid && row_if.row_ready) begin
        row_if.row_valid <= 1'b0;
      end

      done <= (state == DRAIN) && final_hs;
    end
  end
endmodule

// File: tb/tb_ref_row_feeder.sv
// Directed bench for ref_row_feeder: scoreboard of expected rows popped by a handshake monitor.
module tb_ref_row_feeder;
  localparam int PIX_W    = 8;
  localparam int ROW_PIX  = 15;
  localparam int NUM_ROWS = 15;
  localparam int AW       = 20;
  localparam int CW       = 16;
  localparam int RW       = ROW_PIX * PIX_W;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 start = 1'b0;
  logic signed [CW-1:0] blk_x = '0;
  logic signed [CW-1:0] blk_y = '0;
  logic [CW-1:0]        pic_w = 16'd64;
  logic [CW-1:0]        pic_h = 16'd64;
  logic                 mem_rd_en;
  logic [AW-1:0]        mem_addr;
  logic [PIX_W-1:0]     mem_rd_data = '0;
  logic                 busy, done;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [RW+3:0] exp_q[$];
  logic [RW-1:0] got[NUM_ROWS];

  ref_row_feeder_if #(.PIX_W(PIX_W), .ROW_PIX(ROW_PIX)) rif();

  ref_row_feeder #(
    .PIX_W(PIX_W), .ROW_PIX(ROW_PIX), .NUM_ROWS(NUM_ROWS), .AW(AW), .CW(CW)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .blk_x(blk_x), .blk_y(blk_y), .pic_w(pic_w), .pic_h(pic_h),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .row_if(rif), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Frame memory: mem[a] = a[7:0], one-cycle read latency.
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem_addr[7:0];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [RW-1:0] model_row(int bx, int by, int w, int h, int r);
    logic [RW-1:0] v;
    int x, y, a;
    v = '0;
    y = by + r;
    if (y < 0) y = 0;
    if (y > h - 1) y = h - 1;
    for (int j = 0; j < ROW_PIX; j++) begin
      x = bx + j;
      if (x < 0) x = 0;
      if (x > w - 1) x = w - 1;
      a = y * w + x;
      v[j*PIX_W +: PIX_W] = PIX_W'(a & 255);
    end
    return v;
  endfunction

  always @(negedge clk) begin
    if (rst && rif.row_valid && rif.row_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL sb_extra: row idx %0d arrived, none expected", rif.row_idx);
      end else begin
        logic [RW+3:0] e;
        e = exp_q.pop_front();
        chk($sformatf("sb_idx_%0d", e[RW+3:RW]), rif.row_idx, e[RW+3:RW]);
        chk($sformatf("sb_row_%0d", e[RW+3:RW]), rif.row_out, e[RW-1:0]);
        got[rif.row_idx] = rif.row_out;
      end
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_rd_en"}, mem_rd_en, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_valid"}, rif.row_valid, 0);
    chk({tag, "_row"}, rif.row_out, 0);
    chk({tag, "_idx"}, rif.row_idx, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  // k counts edges after the start-sampling edge E0.
  task automatic run(input int bx, input int by, input int w, input int h,
                     input int stall, input bit pulse5, input int abort_k,
                     output int first_rd, output int first_v, output int done_at,
                     output int done_cnt, output int rd_stall);
    logic [RW-1:0] held;
    int k, left;
    blk_x = CW'(bx);
    blk_y = CW'(by);
    pic_w = CW'(w);
    pic_h = CW'(h);
    for (int r = 0; r < NUM_ROWS; r++) begin
      exp_q.push_back({4'(r), model_row(bx, by, w, h, r)});
      got[r] = '0;
    end
    first_rd = -1; first_v = -1; done_at = -1; done_cnt = 0; rd_stall = 0;
    left = 0; held = '0;
    rif.row_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    k = 0;
    while (k < 1000) begin
      @(posedge clk); #1;
      k++;
      start = (pulse5 && k == 4);
      if (pulse5 && k == 4) blk_x = '0;
      if (mem_rd_en && first_rd < 0) first_rd = k;
      if (left > 0) begin
        chk("stall_row", rif.row_out, held);
        chk("stall_idx", rif.row_idx, 0);
        if (mem_rd_en) rd_stall++;
        left--;
        if (left == 0) begin
          chk("stall_rd_off", mem_rd_en, 0);
          rif.row_ready = 1'b1;
        end
      end
      if (rif.row_valid && first_v < 0) begin
        first_v = k;
        if (stall > 0) begin
          rif.row_ready = 1'b0;
          held = rif.row_out;
          left = stall;
          if (mem_rd_en) rd_stall++;
        end
      end
      if (done) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = k;
          chk("busy_with_done", busy, 0);
        end
      end
      if (k == abort_k) begin
        rst = 1'b0;
        #1;
        check_zero("abort");
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        break;
      end
      if (done_at >= 0 && k >= done_at + 20) break;
    end
  endtask

  task automatic t1_checks(input string tag);
    for (int j = 0; j < ROW_PIX; j++)
      chk($sformatf("%s_row0_pix%0d", tag, j), got[0][j*PIX_W +: PIX_W], 138 + j);
    chk({tag, "_row14_pix0"}, got[14][PIX_W-1:0], 10);
  endtask

  initial begin
    int frd, fv, dat, dcnt, rds;
    rif.row_ready = 1'b0;
    #12;
    check_zero("reset");
    @(posedge clk); #1;
    rst = 1'b1;

    // T1 interior
    run(10, 10, 64, 64, 0, 1'b0, -1, frd, fv, dat, dcnt, rds);
    chk("t1_done_cnt", dcnt, 1);
    chk("t1_sb_empty", exp_q.size(), 0);
    t1_checks("t1");

    // T2 top-left corner
    run(-3, -3, 64, 64, 0, 1'b0, -1, frd, fv, dat, dcnt, rds);
    chk("t2_done_cnt", dcnt, 1);
    chk("t2_sb_empty", exp_q.size(), 0);
    for (int r = 0; r < 4; r++)
      for (int j = 0; j < 4; j++)
        chk($sformatf("t2_row%0d_pix%0d", r, j), got[r][j*PIX_W +: PIX_W], 0);
    for (int r = 1; r < 4; r++) chk($sformatf("t2_row%0d_eq_row0", r), got[r], got[0]);
    chk("t2_row0_pix4", got[0][4*PIX_W +: PIX_W], 1);
    chk("t2_row4_pix3", got[4][3*PIX_W +: PIX_W], 64);

    // T3 bottom-right corner
    run(10, 10, 16, 16, 0, 1'b0, -1, frd, fv, dat, dcnt, rds);
    chk("t3_done_cnt", dcnt, 1);
    chk("t3_sb_empty", exp_q.size(), 0);
    for (int r = 0; r < NUM_ROWS; r++) begin
      int yc;
      yc = (r < 5) ? 10 + r : 15;
      for (int j = 5; j < ROW_PIX; j++)
        chk($sformatf("t3_row%0d_pix%0d", r, j), got[r][j*PIX_W +: PIX_W], yc * 16 + 15);
    end
    for (int r = 6; r < NUM_ROWS; r++) chk($sformatf("t3_row%0d_eq_row5", r), got[r], got[5]);

    // T4 backpressure
    run(20, 5, 64, 64, 40, 1'b0, -1, frd, fv, dat, dcnt, rds);
    chk("t4_first_valid", fv, 17);
    chk("t4_reads_in_stall", rds, 14);
    chk("t4_done_cnt", dcnt, 1);
    chk("t4_sb_empty", exp_q.size(), 0);

    // T5 continuous timing, with a start pulse while busy
    run(0, 30, 64, 64, 0, 1'b1, -1, frd, fv, dat, dcnt, rds);
    chk("t5_first_rd", frd, 1);
    chk("t5_first_valid", fv, 17);
    chk("t5_done_at", dat, 228);
    chk("t5_done_cnt", dcnt, 1);
    chk("t5_sb_empty", exp_q.size(), 0);

    // T6 reset during row 6 fetch, then a clean window
    run(10, 10, 64, 64, 0, 1'b0, 95, frd, fv, dat, dcnt, rds);
    chk("t6_no_done", dcnt, 0);
    run(10, 10, 64, 64, 0, 1'b0, -1, frd, fv, dat, dcnt, rds);
    chk("t6_first_valid", fv, 17);
    chk("t6_done_cnt", dcnt, 1);
    chk("t6_sb_empty", exp_q.size(), 0);
    t1_checks("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end
endmodule
